irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_IRQ, default 8: number of external interrupt lines, 1..24.
REQ-002 Parameter TMR_W, default 32: timer counter and limit width.
REQ-003 Parameter VEC_BASE, default 32'h0000_0100: vector base for non-NMI causes.
REQ-004 Parameter NMI_VEC, default 32'h0000_0080: fixed NMI handler address.
REQ-005 Ports, in order (name, direction, width, meaning):
- clk_i, in, 1: the single clock; all state updates on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- en_inter, in, 1: global enable for all maskable sources.
- en_ecall, en_tmr, in, 1 each: per-source enables.
- en_int, in, NUM_IRQ: per-line external enables.
- nmi, in, 1: non-maskable request, rising-edge sensitive.
- ecall, ebreak, in, 1 each: one-cycle exception pulses from EX.
- int_lines, in, NUM_IRQ: external lines, rising-edge sensitive.
- limit, in, TMR_W: timer period; 0 disables the timer.
- irq_ready, in, 1: pipeline accepts the redirect.
- epc_i, in, 32: PC to save on accept.
- mret_i, in, 1: one-cycle return-from-handler pulse.
- irq_valid, out, 1: redirect request.
- vec_addr, out, 32: handler address.
- cause, out, 8: cause code of the pending request.
- mepc_o, out, 32: saved PC.
- in_service, out, 1: a handler is active.
- pending_o, out, NUM_IRQ+4: pending vector, indexed by cause.

Function
REQ-006 Cause codes: 0 NMI, 1 ebreak, 2 ecall, 3 timer, 4+i external line i.
REQ-007 Priority order: lowest cause code wins.
REQ-008 Edge detection on nmi and int_lines: register the previous sample; a 0->1 transition sets the pending bit on the next edge. ecall and ebreak pulses set their pending bits directly.
REQ-009 A source whose pending bit is set and whose enable is 0 stays pending; it becomes eligible once enabled.
REQ-010 NMI and ebreak ignore every enable, including en_inter.
REQ-011 Eligible sources:
- NMI and ebreak: whenever pending.
- ecall: pending & en_ecall & en_inter.
- Timer: pending & en_tmr & en_inter.
- External line i: pending & en_int[i] & en_inter.
REQ-012 Timer counter:
- Increments every cycle while limit != 0.
- When count >= limit-1, it sets timer pending and loads 0 on the same edge.
- A limit lowered below the current count triggers on the next cycle.
- limit = 0 holds the count at 0.
REQ-013 The FSM has three states: IDLE, REQ, SERVICE.
REQ-014 IDLE: if any source is eligible, go to REQ, latching the winning cause.
REQ-015 REQ behaviour:
- irq_valid = 1.
- cause is the latched value; vec_addr = NMI_VEC for cause 0, otherwise VEC_BASE + 4*cause.
- Both outputs stay stable until irq_ready, even if higher-priority sources arrive meanwhile.
REQ-016 On irq_valid & irq_ready:
- mepc <= epc_i.
- The latched cause's pending bit is cleared.
- Go to SERVICE; irq_valid drops on the next cycle.
REQ-017 SERVICE: in_service = 1; no new request is raised, including NMI; mret_i returns to IDLE. Request latency is 1 cycle: if sources are eligible on the mret edge, irq_valid asserts on the following cycle.
REQ-018 mret_i outside SERVICE is ignored.
REQ-019 If a new event arrives on the same edge that clears that source's pending bit, the bit remains set.
REQ-020 Multiple edges on one source before it is serviced coalesce into a single pending event.
REQ-021 mepc_o always reflects the last saved value.
REQ-022 pending_o is the raw pending register, not masked by enables.

Reset
REQ-023 While rst_n = 0, asynchronously force:
- state = IDLE; pending = 0; edge registers = 0; count = 0; mepc = 0.
- irq_valid = 0; vec_addr = 0; cause = 0; in_service = 0.
REQ-024 Reset asserted in REQ or SERVICE abandons the request; no mepc capture occurs.
REQ-025 The first edge-detect sample after reset release does not generate an event for lines already high.

Structure
REQ-026 Package irq_pkg holds: the cause code constants, the FSM state enum, and the default NMI_VEC/VEC_BASE.
REQ-027 The timer is the sub-module irq_timer (clk_i, rst_n, limit, tick); the priority encoder and FSM are in irq_controller.

Verification
REQ-028 NUM_IRQ=8, en_inter=1, en_int=8'h04; pulse int_lines[2] -> irq_valid within 2 cycles, cause=6, vec_addr=32'h118; irq_ready with epc_i=32'h40 -> mepc_o=32'h40, pending_o[6]=0, in_service=1.
REQ-029 Same cycle: int_lines[0] rise and nmi rise, all enabled -> cause=0 and vec_addr=32'h80 first; after mret, cause=4 is raised.
REQ-030 limit=5, en_tmr=1, irq_ready=0 -> timer pending sets 5 cycles after release and count wraps to 0; set limit=0 -> count holds at 0 with no further ticks.
REQ-031 en_inter=0 with an ecall pulse -> no irq_valid and pending_o[2]=1; raise en_inter=1 -> request with cause=2.
REQ-032 Hold REQ with irq_ready=0 for 10 cycles while nmi rises -> cause stays unchanged; deassert rst_n mid-SERVICE -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the interrupt controller.
//   - cause codes (lowest code = highest priority)
//   - FSM state enum
//   - default vector addresses and a vector-address helper
package irq_pkg;

  localparam logic [7:0] CAUSE_NMI    = 8'd0;
  localparam logic [7:0] CAUSE_EBREAK = 8'd1;
  localparam logic [7:0] CAUSE_ECALL  = 8'd2;
  localparam logic [7:0] CAUSE_TMR    = 8'd3;
  localparam logic [7:0] CAUSE_EXT0   = 8'd4;

  // Number of internal (non-external-line) causes ahead of line 0.
  localparam int unsigned NUM_FIXED = 4;

  localparam logic [31:0] DEF_NMI_VEC  = 32'h0000_0080;
  localparam logic [31:0] DEF_VEC_BASE = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } irq_state_e;

  // NMI jumps to its fixed handler; everything else is table-indexed by cause.
  function automatic logic [31:0] vec_of(input logic [7:0]  c,
                                         input logic [31:0] nmi_vec,
                                         input logic [31:0] vec_base);
    return (c == CAUSE_NMI) ? nmi_vec : vec_base + {22'd0, c, 2'b00};
  endfunction

endpackage

// File: rtl/irq_timer.sv
// irq_timer: free-running period timer.
//   clk_i  - clock
//   rst_n  - asynchronous active-low reset
//   limit  - period in cycles; 0 stops the timer and holds the count at 0
//   tick   - high in the cycle where the count reaches limit-1 (count reloads 0
//            on that same edge)
module irq_timer #(
  parameter int unsigned TMR_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [TMR_W-1:0] limit,
  output logic             tick
);

  logic [TMR_W-1:0] count_q, count_d;

  // '>=' rather than '==' so that lowering limit below the current count
  // fires on the very next edge instead of waiting for a counter wrap.
  always_comb begin
    tick    = 1'b0;
    count_d = count_q + TMR_W'(1);
    if (limit == '0) begin
      count_d = '0;
    end else if (count_q >= limit - TMR_W'(1)) begin
      tick    = 1'b1;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: prioritised interrupt/exception request controller.
//   clk_i, rst_n         - clock, asynchronous active-low reset
//   en_inter             - global enable for maskable sources
//   en_ecall, en_tmr     - per-source enables
//   en_int[NUM_IRQ]      - per-line enables for external lines
//   nmi                  - non-maskable request (rising edge)
//   ecall, ebreak        - one-cycle exception pulses
//   int_lines[NUM_IRQ]   - external lines (rising edge)
//   limit                - timer period, 0 disables
//   irq_ready            - pipeline accepts the redirect
//   epc_i                - PC saved on accept
//   mret_i               - return-from-handler pulse
//   irq_valid/vec_addr/cause - redirect request, handler address, cause code
//   mepc_o               - last saved PC
//   in_service           - a handler is active
//   pending_o            - raw pending register, indexed by cause code
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = 8,
  parameter int unsigned TMR_W    = 32,
  parameter logic [31:0] VEC_BASE = DEF_VEC_BASE,
  parameter logic [31:0] NMI_VEC  = DEF_NMI_VEC
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  input  logic                      en_inter,
  input  logic                      en_ecall,
  input  logic                      en_tmr,
  input  logic [NUM_IRQ-1:0]        en_int,
  input  logic                      nmi,
  input  logic                      ecall,
  input  logic                      ebreak,
  input  logic [NUM_IRQ-1:0]        int_lines,
  input  logic [TMR_W-1:0]          limit,
  input  logic                      irq_ready,
  input  logic [31:0]               epc_i,
  input  logic                      mret_i,
  output logic                      irq_valid,
  output logic [31:0]               vec_addr,
  output logic [7:0]                cause,
  output logic [31:0]               mepc_o,
  output logic                      in_service,
  output logic [NUM_IRQ+3:0]        pending_o
);

  localparam int unsigned NSRC = NUM_IRQ + NUM_FIXED;

  irq_state_e          state_q, state_d;
  logic [NSRC-1:0]     pend_q, pend_d, set_src, clr_src, elig;
  logic                nmi_q;
  logic [NUM_IRQ-1:0]  int_q;
  logic                smp_vld_q;
  logic                tmr_tick;
  logic [7:0]          cause_q, cause_d, win;
  logic [31:0]         vec_q, vec_d, mepc_q, mepc_d;
  logic                any_elig, found, latch, accept;

  irq_timer #(.TMR_W(TMR_W)) u_timer (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .limit (limit),
    .tick  (tmr_tick)
  );

  // Previous-sample registers. smp_vld_q masks the first post-reset edge so
  // lines already high at release are not seen as 0->1 transitions.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      nmi_q     <= 1'b0;
      int_q     <= '0;
      smp_vld_q <= 1'b0;
    end else begin
      nmi_q     <= nmi;
      int_q     <= int_lines;
      smp_vld_q <= 1'b1;
    end
  end

  always_comb begin
    set_src              = '0;
    set_src[CAUSE_NMI]    = nmi & ~nmi_q & smp_vld_q;
    set_src[CAUSE_EBREAK] = ebreak;
    set_src[CAUSE_ECALL]  = ecall;
    set_src[CAUSE_TMR]    = tmr_tick;
    set_src[NSRC-1:NUM_FIXED] = int_lines & ~int_q & {NUM_IRQ{smp_vld_q}};
  end

  always_comb begin
    elig                  = '0;
    elig[CAUSE_NMI]       = pend_q[CAUSE_NMI];
    elig[CAUSE_EBREAK]    = pend_q[CAUSE_EBREAK];
    elig[CAUSE_ECALL]     = pend_q[CAUSE_ECALL] & en_ecall & en_inter;
    elig[CAUSE_TMR]       = pend_q[CAUSE_TMR] & en_tmr & en_inter;
    elig[NSRC-1:NUM_FIXED] = pend_q[NSRC-1:NUM_FIXED] & en_int & {NUM_IRQ{en_inter}};
  end

  // Fixed priority: lowest cause code wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (elig[i] && !found) begin
        win   = 8'(i);
        found = 1'b1;
      end
    end
  end

  assign any_elig = |elig;
  assign accept   = (state_q == ST_REQ) & irq_ready;

  // Set wins over clear so an event landing on the accept edge is not lost.
  always_comb begin
    clr_src = '0;
    if (accept) clr_src = {{(NSRC-1){1'b0}}, 1'b1} << cause_q;
    pend_d = (pend_q & ~clr_src) | set_src;
  end

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. mret with work already eligible goes straight to REQ,
  // keeping the request latency at one cycle.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          state_d = ST_REQ;
          latch   = 1'b1;
        end
      end
      ST_REQ: begin
        if (irq_ready) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (mret_i) begin
          if (any_elig) begin
            state_d = ST_REQ;
            latch   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    irq_valid  = (state_q == ST_REQ);
    in_service = (state_q == ST_SERVICE);
    cause      = cause_q;
    vec_addr   = vec_q;
    mepc_o     = mepc_q;
    pending_o  = pend_q;
  end

  // Cause and vector are latched together so both stay stable through REQ.
  always_comb begin
    cause_d = latch  ? win : cause_q;
    vec_d   = latch  ? vec_of(win, NMI_VEC, VEC_BASE) : vec_q;
    mepc_d  = accept ? epc_i : mepc_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      cause_q <= '0;
      vec_q   <= '0;
      mepc_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      cause_q <= cause_d;
      vec_q   <= vec_d;
      mepc_q  <= mepc_d;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios followed by randomized stimulus, all
// checked each cycle against a behavioural reference model.
module tb_irq_controller;

  localparam int NI = 8;
  localparam int NS = NI + 4;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        en_inter, en_ecall, en_tmr;
  logic [NI-1:0] en_int;
  logic        nmi, ecall, ebreak;
  logic [NI-1:0] int_lines;
  logic [31:0] limit;
  logic        irq_ready;
  logic [31:0] epc_i;
  logic        mret_i;
  logic        irq_valid;
  logic [31:0] vec_addr;
  logic [7:0]  cause;
  logic [31:0] mepc_o;
  logic        in_service;
  logic [NS-1:0] pending_o;

  irq_controller #(
    .NUM_IRQ  (NI),
    .TMR_W    (32),
    .VEC_BASE (32'h0000_0100),
    .NMI_VEC  (32'h0000_0080)
  ) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .en_inter   (en_inter),
    .en_ecall   (en_ecall),
    .en_tmr     (en_tmr),
    .en_int     (en_int),
    .nmi        (nmi),
    .ecall      (ecall),
    .ebreak     (ebreak),
    .int_lines  (int_lines),
    .limit      (limit),
    .irq_ready  (irq_ready),
    .epc_i      (epc_i),
    .mret_i     (mret_i),
    .irq_valid  (irq_valid),
    .vec_addr   (vec_addr),
    .cause      (cause),
    .mepc_o     (mepc_o),
    .in_service (in_service),
    .pending_o  (pending_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          mp[NS];        // pending events
  bit          m_pnmi;
  bit [NI-1:0] m_pint;
  bit          m_seen_edge;   // at least one clock since reset release
  longint      m_cnt;
  int          m_mode;        // 0 waiting, 1 requesting, 2 handler running
  int          m_cause;
  bit [31:0]   m_vec, m_mepc;

  function automatic bit can_take(input int c);
    case (c)
      0, 1:    return mp[c];
      2:       return mp[2] && en_ecall && en_inter;
      3:       return mp[3] && en_tmr && en_inter;
      default: return mp[c] && en_int[c-4] && en_inter;
    endcase
  endfunction

  function automatic int pick();
    for (int c = 0; c < NS; c++) if (can_take(c)) return c;
    return -1;
  endfunction

  function automatic bit [31:0] handler(input int c);
    return (c == 0) ? 32'h80 : 32'h100 + 32'(4 * c);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NS; c++) mp[c] = 0;
    m_pnmi = 0; m_pint = '0; m_seen_edge = 0; m_cnt = 0;
    m_mode = 0; m_cause = 0; m_vec = '0; m_mepc = '0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit     ev[NS];
    int     w;
    longint lim;
    w   = pick();
    lim = longint'(limit);
    ev[0] = m_seen_edge && nmi && !m_pnmi;
    ev[1] = ebreak;
    ev[2] = ecall;
    ev[3] = (lim != 0) && (m_cnt >= lim - 1);
    for (int i = 0; i < NI; i++) ev[4+i] = m_seen_edge && int_lines[i] && !m_pint[i];
    if (lim == 0 || ev[3]) m_cnt = 0; else m_cnt = m_cnt + 1;

    if (m_mode == 1) begin
      if (irq_ready) begin
        mp[m_cause] = 0;
        m_mepc = epc_i;
        m_mode = 2;
      end
    end else if (m_mode == 0) begin
      if (w >= 0) begin m_mode = 1; m_cause = w; m_vec = handler(w); end
    end else if (mret_i) begin
      if (w >= 0) begin m_mode = 1; m_cause = w; m_vec = handler(w); end
      else m_mode = 0;
    end
    for (int c = 0; c < NS; c++) if (ev[c]) mp[c] = 1;
    m_pnmi = nmi; m_pint = int_lines; m_seen_edge = 1;
  endtask

  task automatic check_all();
    logic [NS-1:0] pk;
    for (int c = 0; c < NS; c++) pk[c] = mp[c];
    chk("irq_valid",  64'(irq_valid),  64'(m_mode == 1));
    chk("in_service", 64'(in_service), 64'(m_mode == 2));
    chk("cause",      64'(cause),      64'(m_cause));
    chk("vec_addr",   64'(vec_addr),   64'(m_vec));
    chk("mepc",       64'(mepc_o),     64'(m_mepc));
    chk("pending",    64'(pending_o),  64'(pk));
  endtask

  task automatic tick1();
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    check_all();
  endtask

  task automatic clear_inputs();
    en_inter = 0; en_ecall = 0; en_tmr = 0; en_int = '0;
    nmi = 0; ecall = 0; ebreak = 0; int_lines = '0;
    limit = '0; irq_ready = 0; epc_i = '0; mret_i = 0;
  endtask

  task automatic serve();
    irq_ready = 1; tick1(); irq_ready = 0;
    mret_i = 1; tick1(); mret_i = 0;
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 0;
    #1;
    chk({tag, "_valid"},   64'(irq_valid),  64'd0);
    chk({tag, "_insvc"},   64'(in_service), 64'd0);
    chk({tag, "_cause"},   64'(cause),      64'd0);
    chk({tag, "_vec"},     64'(vec_addr),   64'd0);
    chk({tag, "_mepc"},    64'(mepc_o),     64'd0);
    chk({tag, "_pending"}, 64'(pending_o),  64'd0);
    model_reset();
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check_all();
    rst_n = 1;
    tick1();

    // External line 2 through to service.
    en_inter = 1; en_int = 8'h04; int_lines = 8'h04;
    tick1();
    int_lines = '0;
    tick1();
    chk("ext2_valid", 64'(irq_valid), 64'd1);
    chk("ext2_cause", 64'(cause),     64'd6);
    chk("ext2_vec",   64'(vec_addr),  64'h118);
    irq_ready = 1; epc_i = 32'h40;
    tick1();
    irq_ready = 0;
    chk("ext2_mepc",  64'(mepc_o),       64'h40);
    chk("ext2_pend6", 64'(pending_o[6]), 64'd0);
    chk("ext2_insvc", 64'(in_service),   64'd1);
    mret_i = 1; tick1(); mret_i = 0;
    chk("ext2_idle",  64'(irq_valid),    64'd0);

    // NMI and line 0 on the same edge.
    en_int = 8'hFF; en_ecall = 1; en_tmr = 1;
    nmi = 1; int_lines = 8'h01;
    tick1();
    nmi = 0; int_lines = '0;
    tick1();
    chk("nmi_cause", 64'(cause),    64'd0);
    chk("nmi_vec",   64'(vec_addr), 64'h80);
    irq_ready = 1; epc_i = 32'h1234; tick1(); irq_ready = 0;
    mret_i = 1; tick1(); mret_i = 0;
    chk("after_nmi_valid", 64'(irq_valid), 64'd1);
    chk("after_nmi_cause", 64'(cause),     64'd4);
    serve();

    // ecall masked globally, then unmasked.
    en_inter = 0; ecall = 1; tick1(); ecall = 0;
    repeat (3) tick1();
    chk("ecall_masked_valid", 64'(irq_valid),    64'd0);
    chk("ecall_masked_pend",  64'(pending_o[2]), 64'd1);
    en_inter = 1; tick1();
    chk("ecall_valid", 64'(irq_valid), 64'd1);
    chk("ecall_cause", 64'(cause),     64'd2);
    serve();

    // REQ held while NMI rises; then reset mid-service.
    ebreak = 1; tick1(); ebreak = 0; tick1();
    for (int k = 0; k < 10; k++) begin
      nmi = (k >= 3);
      tick1();
      chk("hold_cause", 64'(cause), 64'd1);
    end
    nmi = 0;
    irq_ready = 1; epc_i = 32'hABCD; tick1(); irq_ready = 0;
    chk("hold_insvc", 64'(in_service), 64'd1);
    async_reset_check("rst_svc");

    // Timer with limit 5; lines already high at release must not fire.
    @(negedge clk_i);
    check_all();
    limit = 32'd5; en_tmr = 1; en_inter = 1; en_int = 8'hFF;
    int_lines = 8'hFF; nmi = 1;
    rst_n = 1;
    repeat (4) tick1();
    chk("tmr_early", 64'(pending_o[3]), 64'd0);
    tick1();
    chk("tmr_fire",  64'(pending_o[3]), 64'd1);
    chk("no_lvl_evt", 64'({pending_o[NS-1:4], pending_o[0]}), 64'd0);
    repeat (3) tick1();
    limit = '0;
    serve();
    repeat (20) tick1();
    chk("tmr_off", 64'(pending_o[3]), 64'd0);
    int_lines = '0; nmi = 0;
    tick1();

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset_check("rst_rand");
        @(negedge clk_i);
        check_all();
        rst_n = 1;
        continue;
      end
      irq_ready = ($urandom_range(0, 9) < 3);
      mret_i    = ($urandom_range(0, 99) < 15);
      ecall     = ($urandom_range(0, 99) < 5);
      ebreak    = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 5) nmi = ~nmi;
      for (int i = 0; i < NI; i++)
        if ($urandom_range(0, 9) == 0) int_lines[i] = ~int_lines[i];
      if ($urandom_range(0, 19) == 0) en_inter = ~en_inter;
      if ($urandom_range(0, 19) == 0) en_ecall = ~en_ecall;
      if ($urandom_range(0, 19) == 0) en_tmr   = ~en_tmr;
      if ($urandom_range(0, 19) == 0) en_int   = 8'($urandom);
      if ($urandom_range(0, 32) == 0) limit    = 32'($urandom_range(0, 12));
      epc_i = $urandom;
      tick1();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
